// File: rtl/dinorun_pkg.sv
// Shared types and constants for the dinorun game blocks.
// Holds the game state encoding, screen constants and the spawn threshold helper.
package dinorun_pkg;

  typedef enum logic [1:0] {
    TITLE    = 2'd0,
    RUN      = 2'd1,
    HIT      = 2'd2,
    GAMEOVER = 2'd3
  } game_state_e;

  localparam int unsigned GROUND_Y         = 400;
  localparam logic [11:0] COLOR_BG         = 12'hFFF;
  localparam logic [11:0] COLOR_FG         = 12'h555;
  localparam int unsigned DEF_FLASH_FRAMES = 60;
  localparam int unsigned DEF_LIVES        = 3;

  // SpawnBase << level, clamped so it still compares against an 8-bit random byte
  function automatic logic [7:0] spawn_thresh(input logic [7:0] base, input logic [2:0] level);
    logic [15:0] t;
    t = {8'd0, base} << level;
    return (t > 16'd255) ? 8'hFF : t[7:0];
  endfunction

endpackage

// File: rtl/dinorun_game_ctrl_rr_spawn_arbiter.sv
// Round-robin spawn arbiter: picks the first inactive obstacle channel at or after the pointer.
// Pure combinational; the caller owns the pointer register.
module rr_spawn_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          req,
  input  logic [N-1:0]  inactive,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr,
  output logic          granted
);

  always_comb begin
    int idx;
    grant    = '0;
    next_ptr = ptr;
    granted  = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req && !granted && inactive[idx]) begin
        granted    = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/dinorun_game_ctrl.sv
// Dinorun game controller: title/run/hit/game-over FSM, lives, levels and
// round-robin obstacle spawning on frame boundaries.
module dinorun_game_ctrl
  import dinorun_pkg::*;
#(
  parameter int NumObstacles = 4,
  parameter int FlashFrames  = DEF_FLASH_FRAMES,
  parameter int Lives        = DEF_LIVES,
  parameter int BlinkBit     = 3,
  parameter int GapFrames    = 20,
  parameter int SpawnBase    = 8,
  parameter int LevelFrames  = 600,
  parameter int MaxLevel     = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vsync_edge_i,
  input  logic                    start_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic [15:0]             rand_i,
  input  logic                    collision_i,
  input  logic [NumObstacles-1:0] obstacle_active_i,
  output logic [1:0]              state_o,
  output logic                    next_frame_o,
  output logic [NumObstacles-1:0] spawn_o,
  output logic                    reset_objects_no,
  output logic                    score_clear_no,
  output logic                    score_en_o,
  output logic                    dino_enable_o,
  output logic                    title_en_o,
  output logic [2:0]              lives_o,
  output logic [2:0]              level_o
);

  localparam int PW = (NumObstacles > 1) ? $clog2(NumObstacles) : 1;

  game_state_e state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic [7:0]  flash_q, flash_d;
  logic [7:0]  gap_q, gap_d;
  logic [11:0] lvl_cnt_q, lvl_cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic                    obj_clr, score_clr;
  logic                    run_frame, spawn_req, granted;
  logic [NumObstacles-1:0] grant;
  logic [PW-1:0]           next_ptr;
  logic                    rand_lo_unused;

  assign rand_lo_unused = ^rand_i[7:0];

  // A collision in the same cycle turns the frame into a hit, so nothing spawns
  assign run_frame = vsync_edge_i && (state_q == RUN) && !collision_i;
  assign spawn_req = run_frame && (gap_q == 8'd0) &&
                     (rand_i[15:8] < spawn_thresh(8'(SpawnBase), level_q));

  rr_spawn_arbiter #(.N(NumObstacles), .PW(PW)) u_arb (
    .req      (spawn_req),
    .inactive (~obstacle_active_i),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr),
    .granted  (granted)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    flash_d   = flash_q;
    gap_d     = gap_q;
    lvl_cnt_d = lvl_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    obj_clr   = 1'b0;
    score_clr = 1'b0;
    unique case (state_q)
      TITLE: begin
        if (start_i) begin
          state_d   = RUN;
          obj_clr   = 1'b1;
          score_clr = 1'b1;
        end
      end
      RUN: begin
        if (collision_i) begin
          state_d = HIT;
          flash_d = 8'(FlashFrames);
          lives_d = lives_q - 3'd1;
        end else if (vsync_edge_i) begin
          if (granted) begin
            gap_d    = 8'(GapFrames);
            rr_ptr_d = next_ptr;
          end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
          end
          if (lvl_cnt_q == 12'(LevelFrames - 1)) begin
            lvl_cnt_d = '0;
            if (level_q != 3'(MaxLevel)) level_d = level_q + 3'd1;
          end else begin
            lvl_cnt_d = lvl_cnt_q + 12'd1;
          end
        end
      end
      HIT: begin
        if (vsync_edge_i && flash_q != 8'd0) begin
          flash_d = flash_q - 8'd1;
          if (flash_q == 8'd1) begin
            if (lives_q != 3'd0) begin
              state_d = RUN;
              obj_clr = 1'b1;
            end else begin
              state_d = GAMEOVER;
            end
          end
        end
      end
      GAMEOVER: begin
        if (start_i) begin
          state_d   = RUN;
          obj_clr   = 1'b1;
          score_clr = 1'b1;
        end else if (up_i || down_i) begin
          state_d   = TITLE;
          obj_clr   = 1'b1;
          score_clr = 1'b1;
        end
      end
      default: state_d = TITLE;
    endcase
    // Any entry into RUN with a score clear starts a fresh game
    if (score_clr && state_d == RUN) begin
      lives_d   = 3'(Lives);
      level_d   = '0;
      flash_d   = '0;
      gap_d     = '0;
      lvl_cnt_d = '0;
      rr_ptr_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= TITLE;
      lives_q   <= 3'(Lives);
      level_q   <= '0;
      flash_q   <= '0;
      gap_q     <= '0;
      lvl_cnt_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      flash_q   <= flash_d;
      gap_q     <= gap_d;
      lvl_cnt_q <= lvl_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign state_o          = state_q;
  assign next_frame_o     = rst_ni && vsync_edge_i && (state_q == TITLE || state_q == RUN);
  assign score_en_o       = rst_ni && vsync_edge_i && (state_q == RUN);
  assign spawn_o          = rst_ni ? grant : '0;
  assign reset_objects_no = rst_ni && !obj_clr;
  assign score_clear_no   = rst_ni && !score_clr;
  assign dino_enable_o    = (state_q != HIT) || flash_q[BlinkBit];
  assign title_en_o       = (state_q == TITLE);
  assign lives_o          = lives_q;
  assign level_o          = level_q;

endmodule

// File: tb/tb_dinorun_game_ctrl.sv
// Directed bench for dinorun_game_ctrl: FSM, lives, flashing, levels and spawn scoreboard.
module tb_dinorun_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, start, up, down, collision;
  logic [15:0] rnd;
  logic [3:0]  active;
  logic [1:0]  state;
  logic        next_frame, reset_obj_n, score_clr_n, score_en, dino_en, title_en;
  logic [3:0]  spawn;
  logic [2:0]  lives, level;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  localparam logic [1:0] S_TITLE = 2'd0, S_RUN = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3;

  always #5 clk = ~clk;

  dinorun_game_ctrl #(
    .NumObstacles(4), .FlashFrames(60), .Lives(3), .BlinkBit(3),
    .GapFrames(2), .SpawnBase(8), .LevelFrames(10), .MaxLevel(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .vsync_edge_i(vsync), .start_i(start), .up_i(up),
    .down_i(down), .rand_i(rnd), .collision_i(collision), .obstacle_active_i(active),
    .state_o(state), .next_frame_o(next_frame), .spawn_o(spawn),
    .reset_objects_no(reset_obj_n), .score_clear_no(score_clr_n), .score_en_o(score_en),
    .dino_enable_o(dino_en), .title_en_o(title_en), .lives_o(lives), .level_o(level)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One vsync-pulsed cycle per frame; spawn_o is scored against the queue when it holds entries
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      #3;
      if (exp_q.size() > 0) chk("spawn", 16'(spawn), 16'(exp_q.pop_front()));
      cyc();
      vsync = 1'b0;
    end
  endtask

  task automatic lose_life(input logic [2:0] exp_lives);
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    chk("hit_lives", 16'(lives), 16'(exp_lives));
    frames(59);
    vsync = 1'b1;
    #3;
    chk("hit_end_objclr", 16'(reset_obj_n), (exp_lives != 3'd0) ? 16'd0 : 16'd1);
    cyc();
    vsync = 1'b0;
    chk("hit_end_state", 16'(state), (exp_lives != 3'd0) ? 16'(S_RUN) : 16'(S_OVER));
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; start = 1'b0; up = 1'b0; down = 1'b0;
    collision = 1'b0; rnd = 16'hFFFF; active = 4'b0000;
    #1;
    chk("rst_objclr", 16'(reset_obj_n), 16'd0);
    chk("rst_scoreclr", 16'(score_clr_n), 16'd0);
    chk("rst_next_frame", 16'(next_frame), 16'd0);
    chk("rst_spawn", 16'(spawn), 16'd0);
    vsync = 1'b0;
    cyc(); cyc();
    chk("rst_state", 16'(state), 16'(S_TITLE));
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_level", 16'(level), 16'd0);
    rst_n = 1'b1;
    cyc();
    chk("title_en", 16'(title_en), 16'd1);
    chk("title_clears", {14'd0, reset_obj_n, score_clr_n}, 16'b11);
    vsync = 1'b1;
    #3;
    chk("title_next_frame", 16'(next_frame), 16'd1);
    chk("title_score_en", 16'(score_en), 16'd0);
    cyc();
    vsync = 1'b0;

    // Start from title
    start = 1'b1;
    #3;
    chk("start_clears", {14'd0, reset_obj_n, score_clr_n}, 16'b00);
    cyc();
    start = 1'b0;
    chk("start_state", 16'(state), 16'(S_RUN));
    chk("start_lives", 16'(lives), 16'd3);
    chk("start_level", 16'(level), 16'd0);
    chk("start_clears_off", {14'd0, reset_obj_n, score_clr_n}, 16'b11);
    vsync = 1'b1;
    #3;
    chk("run_score_en", 16'(score_en), 16'd1);
    cyc();
    vsync = 1'b0;
    frames(4);

    // First hit and flashing
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    chk("hit_state", 16'(state), 16'(S_HIT));
    chk("hit_lives", 16'(lives), 16'd2);
    chk("dino_60", 16'(dino_en), 16'd1);
    vsync = 1'b1;
    #3;
    chk("hit_next_frame", 16'(next_frame), 16'd0);
    chk("hit_score_en", 16'(score_en), 16'd0);
    cyc();
    vsync = 1'b0;
    frames(4);
    chk("dino_55", 16'(dino_en), 16'd0);
    frames(8);
    chk("dino_47", 16'(dino_en), 16'd1);
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    chk("hit_ignore_coll", 16'(lives), 16'd2);
    frames(46);
    vsync = 1'b1;
    #3;
    chk("recover_objclr", 16'(reset_obj_n), 16'd0);
    chk("recover_score_kept", 16'(score_clr_n), 16'd1);
    cyc();
    vsync = 1'b0;
    chk("recover_state", 16'(state), 16'(S_RUN));
    chk("recover_objclr_1cyc", 16'(reset_obj_n), 16'd1);

    // Level counter was frozen in HIT: 5 frames before + 5 after reach LevelFrames
    frames(4);
    chk("level_frozen", 16'(level), 16'd0);
    frames(1);
    chk("level_up", 16'(level), 16'd1);

    lose_life(3'd1);
    lose_life(3'd0);
    chk("over_lives", 16'(lives), 16'd0);
    up = 1'b1;
    #3;
    chk("over_up_clears", {14'd0, reset_obj_n, score_clr_n}, 16'b00);
    cyc();
    up = 1'b0;
    chk("over_up_state", 16'(state), 16'(S_TITLE));

    start = 1'b1;
    cyc();
    start = 1'b0;
    lose_life(3'd2);
    lose_life(3'd1);
    lose_life(3'd0);
    start = 1'b1; up = 1'b1;
    #3;
    chk("restart_clears", {14'd0, reset_obj_n, score_clr_n}, 16'b00);
    cyc();
    start = 1'b0; up = 1'b0;
    chk("restart_state", 16'(state), 16'(S_RUN));
    chk("restart_lives", 16'(lives), 16'd3);
    chk("restart_level", 16'(level), 16'd0);

    // Spawn rotation with gap of 2 frames, all channels free
    rnd = 16'h0000;
    for (int i = 0; i < 13; i++)
      exp_q.push_back((i % 3 == 0) ? 4'(1 << ((i / 3) % 4)) : 4'b0000);
    frames(13);
    chk("spawn_level", 16'(level), 16'd1);
    active = 4'b0010;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0100);
    frames(3);

    // Level saturation: 25 RUN frames total
    rnd = 16'hFFFF; active = 4'b0000;
    for (int i = 0; i < 9; i++) exp_q.push_back(4'b0000);
    frames(9);
    chk("level_25", 16'(level), 16'd2);
    frames(10);
    chk("level_sat", 16'(level), 16'd2);

    // Collision beats spawn
    rnd = 16'h0000; vsync = 1'b1; collision = 1'b1;
    #3;
    chk("coll_beats_spawn", 16'(spawn), 16'd0);
    cyc();
    vsync = 1'b0; collision = 1'b0;
    chk("coll_state", 16'(state), 16'(S_HIT));
    chk("coll_lives", 16'(lives), 16'd2);

    // Reset mid-HIT
    frames(30);
    rst_n = 1'b0; vsync = 1'b1;
    #3;
    chk("midrst_spawn", 16'(spawn), 16'd0);
    chk("midrst_clears", {14'd0, reset_obj_n, score_clr_n}, 16'b00);
    cyc();
    chk("midrst_state", 16'(state), 16'(S_TITLE));
    chk("midrst_lives", 16'(lives), 16'd3);
    chk("midrst_level", 16'(level), 16'd0);
    chk("midrst_spawn_next", 16'(spawn), 16'd0);
    vsync = 1'b0; rst_n = 1'b1;
    cyc();
    chk("post_rst_state", 16'(state), 16'(S_TITLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
